// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - 8N1 UART receiver and host command frame decoder
//
// Purpose: receives serial bytes, assembles header+payload frames and issues
//          one update strobe per target (A0 = TG, A1 = SPI, A2 = image buffer)
//          alongside a shared cmd bus.
// Ports:
//   clk40M        in   system clock
//   nRst          in   asynchronous active-low reset
//   serialIn      in   asynchronous UART line, idle high
//   cmd[7:0]      out  last accepted payload, held between updates
//   cmdTgUpdate   out  one-cycle strobe, cmd valid for the timing generator
//   cmdSpiUpdate  out  one-cycle strobe, cmd valid for the SPI master
//   cmdImgUpdate  out  one-cycle strobe, cmd valid for the image buffer
//   frameErr      out  one-cycle strobe on any discarded byte or frame
//   busy          out  high while a frame is in progress
// Build option: CMD_CHECKSUM_EN adds a third frame byte equal to header ^ payload.
module uart_cmd_decoder #(
    parameter int unsigned DVSR        = 347,
    parameter int unsigned TIMEOUT_CYC = 40000,
    parameter logic [7:0]  HDR_TG      = 8'hA0,
    parameter logic [7:0]  HDR_SPI     = 8'hA1,
    parameter logic [7:0]  HDR_IMG     = 8'hA2
) (
    input  logic       clk40M,
    input  logic       nRst,
    input  logic       serialIn,
    output logic [7:0] cmd,
    output logic       cmdTgUpdate,
    output logic       cmdSpiUpdate,
    output logic       cmdImgUpdate,
    output logic       frameErr,
    output logic       busy
);
    localparam logic [8:0]  BIT_LAST  = 9'(DVSR - 1);
    localparam logic [8:0]  HALF_LAST = 9'(DVSR / 2 - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {eIdle, eStart, eData, eStop} rx_state_t;
`ifdef CMD_CHECKSUM_EN
    typedef enum logic [1:0] {eWaitHdr, eWaitPayload, eWaitSum} prs_state_t;
`else
    typedef enum logic [1:0] {eWaitHdr, eWaitPayload} prs_state_t;
`endif

    logic       r_sync1, r_sync2, r_rxPrev;
    rx_state_t  r_rxState, w_rxNext;
    logic [8:0] r_bitTmr;
    logic [2:0] r_bitCnt;
    logic [7:0] r_rxShift;
    logic       r_rxValid, r_rxErr;
    logic       w_tick, w_shiftEn, w_stopOk, w_stopErr, w_fallEdge;

    prs_state_t  r_prsState, w_prsNext;
    logic [1:0]  r_target, w_hdrTgt;
    logic [15:0] r_toCnt;
    logic [7:0]  r_cmd, w_acceptData;
    logic        r_tgUpd, r_spiUpd, r_imgUpd, r_frameErr;
    logic        w_hdrHit, w_hdrOk, w_hdrBad, w_accept, w_sumBad, w_toHit;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]  r_payload, w_hdrByte;
`endif

    // Two-flop synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= serialIn;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end
    assign w_fallEdge = r_rxPrev & ~r_sync2;

    // Rx FSM: state register
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) r_rxState <= eIdle;
        else       r_rxState <= w_rxNext;
    end

    // Rx FSM: next state
    always_comb begin
        w_rxNext = r_rxState;
        case (r_rxState)
            eIdle:   if (w_fallEdge) w_rxNext = eStart;
            eStart:  if (w_tick) w_rxNext = r_sync2 ? eIdle : eData;
            eData:   if (w_tick && (r_bitCnt == 3'd7)) w_rxNext = eStop;
            eStop:   if (w_tick) w_rxNext = eIdle;
            default: w_rxNext = eIdle;
        endcase
    end

    // Rx FSM: outputs. The start bit is sampled half a bit in, every later
    // bit one full bit after the previous sample (bit centres).
    always_comb begin
        w_tick = 1'b0;
        case (r_rxState)
            eStart:       w_tick = (r_bitTmr == HALF_LAST);
            eData, eStop: w_tick = (r_bitTmr == BIT_LAST);
            default:      w_tick = 1'b0;
        endcase
        w_shiftEn = (r_rxState == eData) && w_tick;
        w_stopOk  = (r_rxState == eStop) && w_tick && r_sync2;
        w_stopErr = (r_rxState == eStop) && w_tick && !r_sync2;
    end

    // Rx datapath: bit timer, bit counter, shifter, byte/error pulses
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_bitTmr  <= 9'd0;
            r_bitCnt  <= 3'd0;
            r_rxShift <= 8'h00;
            r_rxValid <= 1'b0;
            r_rxErr   <= 1'b0;
        end else begin
            if (r_rxState == eIdle || w_tick) r_bitTmr <= 9'd0;
            else                              r_bitTmr <= r_bitTmr + 9'd1;
            if (r_rxState == eIdle) r_bitCnt <= 3'd0;
            else if (w_shiftEn)     r_bitCnt <= r_bitCnt + 3'd1;
            if (w_shiftEn) r_rxShift <= {r_sync2, r_rxShift[7:1]};
            r_rxValid <= w_stopOk;
            r_rxErr   <= w_stopErr;
        end
    end

    // Parser FSM: state register
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) r_prsState <= eWaitHdr;
        else       r_prsState <= w_prsNext;
    end

    // Parser FSM: next state. A byte that arrives in the same cycle as the
    // timeout wins over the timeout.
    always_comb begin
        w_prsNext = r_prsState;
        case (r_prsState)
            eWaitHdr: if (w_hdrOk) w_prsNext = eWaitPayload;
`ifdef CMD_CHECKSUM_EN
            eWaitPayload: begin
                if (r_rxValid)               w_prsNext = eWaitSum;
                else if (r_rxErr || w_toHit) w_prsNext = eWaitHdr;
            end
            eWaitSum: if (r_rxValid || r_rxErr || w_toHit) w_prsNext = eWaitHdr;
`else
            eWaitPayload: if (r_rxValid || r_rxErr || w_toHit) w_prsNext = eWaitHdr;
`endif
            default: w_prsNext = eWaitHdr;
        endcase
    end

    // Parser FSM: outputs
    always_comb begin
        w_hdrHit = 1'b1;
        w_hdrTgt = 2'd0;
        case (r_rxShift)
            HDR_TG:  w_hdrTgt = 2'd0;
            HDR_SPI: w_hdrTgt = 2'd1;
            HDR_IMG: w_hdrTgt = 2'd2;
            default: w_hdrHit = 1'b0;
        endcase
        w_hdrOk  = (r_prsState == eWaitHdr) && r_rxValid && w_hdrHit;
        w_hdrBad = (r_prsState == eWaitHdr) && r_rxValid && !w_hdrHit;
        // Timeout only counts idle line time; r_rxValid/r_rxErr already own this cycle.
        w_toHit  = (r_prsState != eWaitHdr) && (r_rxState == eIdle) &&
                   !r_rxValid && !r_rxErr && (r_toCnt == TO_LAST);
`ifdef CMD_CHECKSUM_EN
        case (r_target)
            2'd0:    w_hdrByte = HDR_TG;
            2'd1:    w_hdrByte = HDR_SPI;
            default: w_hdrByte = HDR_IMG;
        endcase
        w_accept     = (r_prsState == eWaitSum) && r_rxValid && (r_rxShift == (w_hdrByte ^ r_payload));
        w_sumBad     = (r_prsState == eWaitSum) && r_rxValid && (r_rxShift != (w_hdrByte ^ r_payload));
        w_acceptData = r_payload;
`else
        w_accept     = (r_prsState == eWaitPayload) && r_rxValid;
        w_sumBad     = 1'b0;
        w_acceptData = r_rxShift;
`endif
    end

    // Parser datapath: target latch, cmd register, strobes, timeout counter
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_target   <= 2'd0;
            r_cmd      <= 8'h00;
            r_tgUpd    <= 1'b0;
            r_spiUpd   <= 1'b0;
            r_imgUpd   <= 1'b0;
            r_frameErr <= 1'b0;
            r_toCnt    <= 16'd0;
`ifdef CMD_CHECKSUM_EN
            r_payload  <= 8'h00;
`endif
        end else begin
            if (w_hdrOk)  r_target <= w_hdrTgt;
            if (w_accept) r_cmd    <= w_acceptData;
            r_tgUpd    <= w_accept && (r_target == 2'd0);
            r_spiUpd   <= w_accept && (r_target == 2'd1);
            r_imgUpd   <= w_accept && (r_target == 2'd2);
            // Stop-bit errors come straight from the Rx sample so they land at S+1.
            r_frameErr <= w_stopErr | w_hdrBad | w_sumBad | w_toHit;
            if (r_prsState == eWaitHdr || r_rxValid) r_toCnt <= 16'd0;
            else if (r_rxState == eIdle)             r_toCnt <= r_toCnt + 16'd1;
`ifdef CMD_CHECKSUM_EN
            if (r_prsState == eWaitPayload && r_rxValid) r_payload <= r_rxShift;
`endif
        end
    end

    assign cmd          = r_cmd;
    assign cmdTgUpdate  = r_tgUpd;
    assign cmdSpiUpdate = r_spiUpd;
    assign cmdImgUpdate = r_imgUpd;
    assign frameErr     = r_frameErr;
    assign busy         = (r_prsState != eWaitHdr);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - scoreboard bench for uart_cmd_decoder
`timescale 1ns/1ps
module tb_uart_cmd_decoder;
    localparam int DVSR        = 87;
    localparam int TIMEOUT_CYC = 3000;
    localparam int HALF        = DVSR / 2;

    logic       clk40M   = 1'b0;
    logic       nRst     = 1'b0;
    logic       serialIn = 1'b1;
    logic [7:0] cmd;
    logic       cmdTgUpdate, cmdSpiUpdate, cmdImgUpdate, frameErr, busy;

    uart_cmd_decoder #(.DVSR(DVSR), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk40M(clk40M), .nRst(nRst), .serialIn(serialIn), .cmd(cmd),
        .cmdTgUpdate(cmdTgUpdate), .cmdSpiUpdate(cmdSpiUpdate),
        .cmdImgUpdate(cmdImgUpdate), .frameErr(frameErr), .busy(busy)
    );

    always #12.5 clk40M = ~clk40M;

    typedef struct {
        bit         is_err;
        int         tgt;
        logic [7:0] data;
        int         lo;
        int         hi;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         errors   = 0;
    logic [7:0] exp_cmd  = 8'h00;
    int         m_phase  = 0;     // 0: header expected, 1: payload, 2: checksum
    int         m_tgt    = 0;
    logic [7:0] m_hdr    = 8'h00;
    logic [7:0] m_pay    = 8'h00;
    int         last_stop = 0;

    always @(posedge clk40M) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_hdr(input logic [7:0] b);
        return (b == 8'hA0) || (b == 8'hA1) || (b == 8'hA2);
    endfunction

    // Reference model: decides the outcome of each received byte from the frame rules.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int t_stop);
        ev_t e;
        e.is_err = 1'b1; e.tgt = 0; e.data = 8'h00;
        e.lo = t_stop + HALF; e.hi = t_stop + HALF + 8;
        if (!stop_ok) begin
            exp_q.push_back(e);
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (is_hdr(b)) begin
                m_phase = 1; m_hdr = b; m_tgt = int'(b) - 160;
            end else exp_q.push_back(e);
        end else if (m_phase == 1) begin
`ifdef CMD_CHECKSUM_EN
            m_pay = b; m_phase = 2;
`else
            e.is_err = 1'b0; e.tgt = m_tgt; e.data = b;
            exp_q.push_back(e);
            m_phase = 0;
`endif
        end else begin
            if (b == (m_hdr ^ m_pay)) begin
                e.is_err = 1'b0; e.tgt = m_tgt; e.data = m_pay;
            end
            exp_q.push_back(e);
            m_phase = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(posedge clk40M); #1 serialIn = 1'b0;
        repeat (DVSR) @(posedge clk40M);
        for (int i = 0; i < 8; i++) begin
            #1 serialIn = b[i];
            repeat (DVSR) @(posedge clk40M);
        end
        #1 serialIn = stop_ok;
        last_stop = cyc;
        model_byte(b, stop_ok, last_stop);
        repeat (DVSR) @(posedge clk40M);
        #1 serialIn = 1'b1;
        check("busy_after_byte", busy, m_phase != 0);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] p);
        send_byte(h, 1'b1);
        send_byte(p, 1'b1);
`ifdef CMD_CHECKSUM_EN
        send_byte(h ^ p, 1'b1);
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd", cmd, 8'h00);
        check("rst_strobes", {cmdImgUpdate, cmdSpiUpdate, cmdTgUpdate}, 3'b000);
        check("rst_frameErr", frameErr, 1'b0);
        check("rst_busy", busy, 1'b0);
    endtask

    // Monitor: pops an expected event whenever the DUT raises any strobe.
    always @(negedge clk40M) begin : mon
        int  n;
        ev_t e;
        if (!nRst) begin
            exp_cmd = 8'h00;
        end else begin
            n = int'(cmdTgUpdate) + int'(cmdSpiUpdate) + int'(cmdImgUpdate) + int'(frameErr);
            if (n > 0) begin
                check("single_output", n, 1);
                check("event_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("event_kind_frameErr", frameErr, e.is_err);
                    checks++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        errors++;
                        $display("FAIL event_cycle: got cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
                    end
                    if (e.is_err) begin
                        check("err_no_strobe", {cmdImgUpdate, cmdSpiUpdate, cmdTgUpdate}, 3'b000);
                    end else begin
                        check("strobe_target", {cmdImgUpdate, cmdSpiUpdate, cmdTgUpdate}, 3'b001 << e.tgt);
                        check("strobe_cmd", cmd, e.data);
                        check("strobe_busy_low", busy, 1'b0);
                        exp_cmd = e.data;
                    end
                end
            end else begin
                check("cmd_hold", cmd, exp_cmd);
                if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
                    check("event_late_cycle", cyc, exp_q[0].hi);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] h, p, s;
        int         r;

        repeat (5) @(posedge clk40M);
        #1 check_reset_outputs();
        nRst = 1'b1;
        repeat (20) @(posedge clk40M);

        // Image update, then TG and SPI updates back to back
        send_frame(8'hA2, 8'h5C);
        send_frame(8'hA0, 8'h33);
        repeat (50) @(posedge clk40M);
        send_frame(8'hA1, 8'hC4);

        // Unknown header, then a valid frame
        send_byte(8'h7F, 1'b1);
        send_frame(8'hA2, 8'h01);

        // Payload with a bad stop bit aborts the frame
        send_byte(8'hA1, 1'b1);
        send_byte(8'h55, 1'b0);
        send_frame(8'hA1, 8'h10);

        // Payload timeout, then an orphan payload is taken as a bad header
        send_byte(8'hA0, 1'b1);
        begin
            ev_t e;
            e.is_err = 1'b1; e.tgt = 0; e.data = 8'h00;
            e.lo = last_stop + TIMEOUT_CYC; e.hi = last_stop + TIMEOUT_CYC + DVSR;
            exp_q.push_back(e);
            m_phase = 0;
        end
        repeat (TIMEOUT_CYC + 20) @(posedge clk40M);
        #1 check("timeout_busy", busy, 1'b0);
        check("timeout_event_seen", exp_q.size(), 0);
        send_byte(8'h22, 1'b1);

        // Short glitch is a false start
        @(posedge clk40M); #1 serialIn = 1'b0;
        repeat (HALF / 2) @(posedge clk40M);
        #1 serialIn = 1'b1;
        repeat (2 * DVSR) @(posedge clk40M);
        #1 check("glitch_busy", busy, 1'b0);

        // Reset in the middle of a payload byte
        send_byte(8'hA2, 1'b1);
        @(posedge clk40M); #1 serialIn = 1'b0;
        repeat (3 * DVSR) @(posedge clk40M);
        #1 nRst = 1'b0;
        m_phase = 0;
        #1 check_reset_outputs();
        serialIn = 1'b1;
        repeat (5) @(posedge clk40M);
        #1 nRst = 1'b1;
        repeat (2 * DVSR) @(posedge clk40M);
        send_frame(8'hA2, 8'hAA);

`ifdef CMD_CHECKSUM_EN
        send_byte(8'hA2, 1'b1); send_byte(8'h0F, 1'b1); send_byte(8'hAD, 1'b1);
        send_byte(8'hA2, 1'b1); send_byte(8'h0F, 1'b1); send_byte(8'h00, 1'b1);
`endif

        // Randomized frames: mostly valid, some bad headers, bad stops, bad sums
        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) h = 8'hA0 + 8'(r % 3);
            else begin
                h = 8'($urandom);
                while (is_hdr(h)) h = 8'($urandom);
            end
            p = 8'($urandom);
            send_byte(h, 1'b1);
            repeat ($urandom_range(0, 100)) @(posedge clk40M);
            send_byte(p, $urandom_range(0, 9) != 0);
`ifdef CMD_CHECKSUM_EN
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (h ^ p);
            send_byte(s, 1'b1);
`else
            s = 8'h00;
`endif
            repeat ($urandom_range(0, 100)) @(posedge clk40M);
        end

        for (int i = 0; i < 20 * DVSR && exp_q.size() > 0; i++) @(posedge clk40M);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
